mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory stage directly downstream of the execute stage. Registers EX results
//  and runs the Dcache request/response handshake for loads and stores. Aligns
//  store data and byte strobes, then extracts and sign- or zero-extends load data.
//  Holds the pipeline through fc while an access is outstanding, and delivers
//  one registered writeback bundle per retired instruction.
// PARAMETERS
//  TIMEOUT_CYCLES  64  Maximum cycles in WAIT before the bus-error abort (>=2).
// PORTS
//  clk              in   1   Clock, rising edge.
//  rst              in   1   Reset, synchronous, active-high.
//  ex_valid_i       in   1   EX bundle valid this cycle.
//  ex_reg_wdata_i   in   32  ALU result / CSR read data; this is the address when ex_mtype_i=1.
//  ex_reg_waddr_i   in   5   Destination register.
//  ex_reg_we_i      in   1   Register write enable.
//  ex_csr_wdata_i   in   32  CSR write data (pass-through).
//  ex_csr_waddr_i   in   12  CSR address (pass-through).
//  ex_csr_we_i      in   1   CSR write enable (pass-through).
//  ex_mtype_i       in   1   1 = memory instruction.
//  ex_mem_rw_i      in   1   0 = load, 1 = store.
//  ex_mem_width_i   in   2   00 byte, 01 half, 10 word, 11 illegal.
//  ex_mem_rdtype_i  in   1   Load extension: 0 = signed, 1 = unsigned.
//  ex_mem_wr_data_i in   32  Store data, right-justified.
//  fc_flush_mem_i   in   1   Kill the instruction captured or in flight.
//  mem_stall_req_o  out  1   To fc: hold EX and earlier stages.
//  mem_dc_req_o     out  1   Dcache request.
//  mem_dc_we_o      out  1   Dcache write.
//  mem_dc_addr_o    out  32  Word-aligned address ({addr[31:2],2'b00}).
//  mem_dc_wdata_o   out  32  Lane-replicated store data.
//  mem_dc_wstrb_o   out  4   Byte strobes.
//  dc_gnt_i         in   1   Dcache accepted the request this cycle.
//  dc_rvalid_i      in   1   Response: load data valid or store acknowledged.
//  dc_rdata_i       in   32  Load word.
//  mem_wb_valid_o   out  1   One-cycle pulse per retired instruction.
//  mem_reg_wdata_o  out  32  Writeback data.
//  mem_reg_waddr_o  out  5   Writeback register.
//  mem_reg_we_o     out  1   Writeback enable.
//  mem_csr_wdata_o  out  32  CSR writeback data.
//  mem_csr_waddr_o  out  12  CSR writeback address.
//  mem_csr_we_o     out  1   CSR writeback enable.
//  mem_misalign_o   out  1   Pulse with mem_wb_valid_o: misaligned or illegal access.
//  mem_bus_err_o    out  1   Pulse: Dcache response timeout.
// BEHAVIOUR
//  Reset:
//   - FSM=IDLE; every output and internal register is 0.
//   - Reset asserted in any state aborts the access; a later rvalid is ignored.
//  Capture:
//   - The EX bundle is taken only when ex_valid_i=1, mem_stall_req_o=0 and fc_flush_mem_i=0.
//  Non-memory instruction:
//   - All wb/csr outputs are registered with one-cycle latency.
//   - mem_wb_valid_o pulses; no stall.
//  Alignment (off = addr[1:0]):
//   - Half with off[0]=1, word with off!=0, or width=11 is misaligned.
//   - Misaligned: no Dcache request; next cycle mem_wb_valid_o=1, mem_misalign_o=1, reg_we=0, csr_we=0.
//  FSM:
//   - IDLE->REQ on capture of an aligned memory op.
//   - REQ: mem_dc_req_o=1; addr, we, wdata and wstrb are held stable. On dc_gnt_i go to WAIT.
//   - WAIT: mem_dc_req_o=0 and the counter increments every cycle.
//   - WAIT->IDLE on dc_rvalid_i: load writes formatted data; a store sets reg_we=0.
//     mem_wb_valid_o pulses the next cycle.
//   - If the counter reaches TIMEOUT_CYCLES-1 in WAIT without rvalid: pulse mem_bus_err_o,
//     go to IDLE, no mem_wb_valid_o.
//  Stall:
//   - mem_stall_req_o=1 in REQ and WAIT (registered from the next state).
//   - It falls in the cycle mem_wb_valid_o pulses.
//  Store lanes:
//   - byte: wdata={4{d[7:0]}}, wstrb=0001<<off.
//   - half: wdata={2{d[15:0]}}, wstrb=0011<<off.
//   - word: wdata=d, wstrb=1111.
//  Load format:
//   - s = rdata>>(8*off).
//   - byte: signed -> sext(s[7:0]), unsigned -> zext(s[7:0]).
//   - half: signed -> sext(s[15:0]), unsigned -> zext(s[15:0]).
//   - word: s unchanged.
//  Flush:
//   - IDLE: the input is not captured.
//   - REQ with dc_gnt_i=0 in the same cycle: drop req and go to IDLE.
//   - REQ with gnt in the same cycle, or WAIT: set kill, stay until rvalid/timeout,
//     retire with no wb pulse and no error pulse.
//  Simultaneous gnt+rvalid in REQ: treat as the rvalid completion.
//  rvalid in IDLE/REQ (stale): ignored.
// TESTING
//  1. ALU op, reg_wdata=0x1234, waddr=5, we=1 -> next cycle wb_valid=1, wdata=0x1234,
//     waddr=5; stall stays 0.
//  2. LB at 0x1003, rdata=0x80AABBCC -> wdata=0xFFFFFF80. Same access as LBU -> 0x00000080.
//  3. SH at 0x2002, data=0x0000BEEF -> dc_addr=0x2000, dc_wdata=0xBEEFBEEF,
//     wstrb=1100, we=1; retire with reg_we=0.
//  4. LW, gnt delayed 3 cycles, rvalid 2 cycles later -> req and addr stable;
//     stall=1 throughout; exactly one wb_valid.
//  5. LW at 0x1002 -> dc_req never asserted; misalign=1 with wb_valid and reg_we=0.
//  6. TIMEOUT_CYCLES=16, no rvalid -> bus_err at WAIT cycle 16. Flush in WAIT -> no
//     wb_valid, stall held until rvalid. rst mid-WAIT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: registers the EX bundle, runs the Dcache request/response
// handshake for loads and stores, aligns store lanes, formats load data and
// emits one registered writeback pulse per retired instruction.
//
// Dcache handshake: mem_dc_req_o is a valid held high, with address, write
// flag, data and strobes frozen, until the cycle dc_gnt_i is seen with it.
// The response arrives later as a single-cycle dc_rvalid_i. A dc_rvalid_i
// that arrives while no access has been granted is stale and is ignored.
// The one exception is a dc_rvalid_i in the grant cycle itself, which
// completes the access.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_reg_wdata_i,
  input  logic [4:0]  ex_reg_waddr_i,
  input  logic        ex_reg_we_i,
  input  logic [31:0] ex_csr_wdata_i,
  input  logic [11:0] ex_csr_waddr_i,
  input  logic        ex_csr_we_i,
  input  logic        ex_mtype_i,
  input  logic        ex_mem_rw_i,
  input  logic [1:0]  ex_mem_width_i,
  input  logic        ex_mem_rdtype_i,
  input  logic [31:0] ex_mem_wr_data_i,
  input  logic        fc_flush_mem_i,
  output logic        mem_stall_req_o,
  output logic        mem_dc_req_o,
  output logic        mem_dc_we_o,
  output logic [31:0] mem_dc_addr_o,
  output logic [31:0] mem_dc_wdata_o,
  output logic [3:0]  mem_dc_wstrb_o,
  input  logic        dc_gnt_i,
  input  logic        dc_rvalid_i,
  input  logic [31:0] dc_rdata_i,
  output logic        mem_wb_valid_o,
  output logic [31:0] mem_reg_wdata_o,
  output logic [4:0]  mem_reg_waddr_o,
  output logic        mem_reg_we_o,
  output logic [31:0] mem_csr_wdata_o,
  output logic [11:0] mem_csr_waddr_o,
  output logic        mem_csr_we_o,
  output logic        mem_misalign_o,
  output logic        mem_bus_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // FSM state; visible hierarchically for checkers.
  state_t        state;
  logic [CW-1:0] cnt;
  logic          kill;

  // Fields of the captured memory op, used when it retires.
  logic [4:0]    reg_waddr_q;
  logic          reg_we_q;
  logic [31:0]   csr_wdata_q;
  logic [11:0]   csr_waddr_q;
  logic          csr_we_q;
  logic          rw_q;
  logic [1:0]    width_q;
  logic          rdtype_q;
  logic [1:0]    off_q;

  logic          capture;
  logic          misalign_c;
  logic [1:0]    off_c;
  logic [31:0]   wdata_c;
  logic [3:0]    wstrb_c;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic          retire;
  logic          kill_now;

  // Capture qualification and the store-lane and misalignment decode of the EX bundle.
  always_comb begin
    capture    = ex_valid_i && !mem_stall_req_o && !fc_flush_mem_i;
    off_c      = ex_reg_wdata_i[1:0];
    misalign_c = (ex_mem_width_i == 2'b11) ||
                 ((ex_mem_width_i == 2'b01) && off_c[0]) ||
                 ((ex_mem_width_i == 2'b10) && (off_c != 2'b00));
    wdata_c    = ex_mem_wr_data_i;
    wstrb_c    = 4'b1111;
    case (ex_mem_width_i)
      2'b00: begin
        wdata_c = {4{ex_mem_wr_data_i[7:0]}};
        wstrb_c = 4'b0001 << off_c;
      end
      2'b01: begin
        wdata_c = {2{ex_mem_wr_data_i[15:0]}};
        wstrb_c = 4'b0011 << off_c;
      end
      default: begin
        wdata_c = ex_mem_wr_data_i;
        wstrb_c = 4'b1111;
      end
    endcase
  end

  // Load extraction and extension, plus the completion and kill decode.
  always_comb begin
    shifted = dc_rdata_i >> {off_q, 3'b000};
    case (width_q)
      2'b00:   load_data = rdtype_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = rdtype_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
    // A flush in the completing cycle also kills the writeback.
    kill_now = kill || fc_flush_mem_i;
    retire   = ((state == S_REQ) && dc_gnt_i && dc_rvalid_i) ||
               ((state == S_WAIT) && dc_rvalid_i);
  end

  // Pipeline register and Dcache FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      kill            <= 1'b0;
      reg_waddr_q     <= '0;
      reg_we_q        <= 1'b0;
      csr_wdata_q     <= '0;
      csr_waddr_q     <= '0;
      csr_we_q        <= 1'b0;
      rw_q            <= 1'b0;
      width_q         <= '0;
      rdtype_q        <= 1'b0;
      off_q           <= '0;
      mem_stall_req_o <= 1'b0;
      mem_dc_req_o    <= 1'b0;
      mem_dc_we_o     <= 1'b0;
      mem_dc_addr_o   <= '0;
      mem_dc_wdata_o  <= '0;
      mem_dc_wstrb_o  <= '0;
      mem_wb_valid_o  <= 1'b0;
      mem_reg_wdata_o <= '0;
      mem_reg_waddr_o <= '0;
      mem_reg_we_o    <= 1'b0;
      mem_csr_wdata_o <= '0;
      mem_csr_waddr_o <= '0;
      mem_csr_we_o    <= 1'b0;
      mem_misalign_o  <= 1'b0;
      mem_bus_err_o   <= 1'b0;
    end else begin
      // Pulses and write enables are only ever high for one cycle.
      mem_wb_valid_o <= 1'b0;
      mem_misalign_o <= 1'b0;
      mem_bus_err_o  <= 1'b0;
      mem_reg_we_o   <= 1'b0;
      mem_csr_we_o   <= 1'b0;
      if (retire) begin
        state           <= S_IDLE;
        mem_stall_req_o <= 1'b0;
        mem_dc_req_o    <= 1'b0;
        kill            <= 1'b0;
        cnt             <= '0;
        if (!kill_now) begin
          mem_wb_valid_o  <= 1'b1;
          mem_reg_wdata_o <= rw_q ? 32'h0 : load_data;
          mem_reg_waddr_o <= reg_waddr_q;
          mem_reg_we_o    <= reg_we_q && !rw_q;
          mem_csr_wdata_o <= csr_wdata_q;
          mem_csr_waddr_o <= csr_waddr_q;
          mem_csr_we_o    <= csr_we_q;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (capture) begin
              reg_waddr_q <= ex_reg_waddr_i;
              reg_we_q    <= ex_reg_we_i;
              csr_wdata_q <= ex_csr_wdata_i;
              csr_waddr_q <= ex_csr_waddr_i;
              csr_we_q    <= ex_csr_we_i;
              rw_q        <= ex_mem_rw_i;
              width_q     <= ex_mem_width_i;
              rdtype_q    <= ex_mem_rdtype_i;
              off_q       <= off_c;
              if (!ex_mtype_i || misalign_c) begin
                // Retires next cycle without touching the Dcache.
                mem_wb_valid_o  <= 1'b1;
                mem_misalign_o  <= ex_mtype_i;
                mem_reg_wdata_o <= ex_reg_wdata_i;
                mem_reg_waddr_o <= ex_reg_waddr_i;
                mem_reg_we_o    <= ex_reg_we_i && !ex_mtype_i;
                mem_csr_wdata_o <= ex_csr_wdata_i;
                mem_csr_waddr_o <= ex_csr_waddr_i;
                mem_csr_we_o    <= ex_csr_we_i && !ex_mtype_i;
              end else begin
                state           <= S_REQ;
                mem_stall_req_o <= 1'b1;
                kill            <= 1'b0;
                mem_dc_req_o    <= 1'b1;
                mem_dc_we_o     <= ex_mem_rw_i;
                mem_dc_addr_o   <= {ex_reg_wdata_i[31:2], 2'b00};
                mem_dc_wdata_o  <= wdata_c;
                mem_dc_wstrb_o  <= wstrb_c;
              end
            end
          end
          S_REQ: begin
            if (dc_gnt_i) begin
              // Once granted the access must drain, so a flush only marks it killed.
              state        <= S_WAIT;
              mem_dc_req_o <= 1'b0;
              cnt          <= '0;
              kill         <= fc_flush_mem_i;
            end else if (fc_flush_mem_i) begin
              state           <= S_IDLE;
              mem_dc_req_o    <= 1'b0;
              mem_stall_req_o <= 1'b0;
            end
          end
          S_WAIT: begin
            if (cnt == CNT_LAST) begin
              state           <= S_IDLE;
              mem_stall_req_o <= 1'b0;
              mem_bus_err_o   <= !kill_now;
              kill            <= 1'b0;
              cnt             <= '0;
            end else begin
              cnt <= cnt + 1'b1;
              if (fc_flush_mem_i) kill <= 1'b1;
            end
          end
          default: begin
            state           <= S_IDLE;
            mem_stall_req_o <= 1'b0;
            mem_dc_req_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
